// File: rtl/tdc_axil_regs_if.sv
// AXI4-Lite bus bundle for the TDC register file.
// The slave modport is the register-file side; the master modport is the bus-master side.
interface tdc_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tdc_axil_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers for the TDC core.
// Independent single-outstanding write and read FSMs; every access answers OKAY.
module tdc_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    tdc_axil_regs_if.slave                    s00_axi,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
    output logic [3:0]                        reg_wr_o
);
    localparam int NREG  = 4;
    localparam int NBYTE = C_S_AXI_DATA_WIDTH / 8;

    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} rstate_t;

    wstate_t            wstate_q, wstate_d;
    rstate_t            rstate_q, rstate_d;
    logic [1:0]         widx_q, widx_d;
    word_t              wdata_q, wdata_d;
    logic [NBYTE-1:0]   wstrb_q, wstrb_d;
    logic [1:0]         ridx_q, ridx_d;
    word_t              rdata_q, rdata_d;
    word_t              regs_q [NREG];
    word_t              regs_d [NREG];
    logic [3:0]         reg_wr_q, reg_wr_d;

    // Protection bits and the byte offset inside a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot,
                           s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    always_comb begin
        wstate_d = wstate_q;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        regs_d   = regs_q;
        reg_wr_d = '0;
        case (wstate_q)
            W_IDLE: begin
                if (s00_axi.awvalid && s00_axi.wvalid) begin
                    widx_d   = s00_axi.awaddr[3:2];
                    wdata_d  = s00_axi.wdata;
                    wstrb_d  = s00_axi.wstrb;
                    wstate_d = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                for (int b = 0; b < NBYTE; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[widx_q][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
                reg_wr_d[widx_q] = 1'b1;
                wstate_d         = W_RESP;
            end
            W_RESP: begin
                if (s00_axi.bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read side samples regs_q, so a same-edge write is seen only by the next read.
    always_comb begin
        rstate_d = rstate_q;
        ridx_d   = ridx_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (s00_axi.arvalid) begin
                    ridx_d   = s00_axi.araddr[3:2];
                    rstate_d = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                rdata_d  = regs_q[ridx_q];
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (s00_axi.rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            widx_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ridx_q   <= '0;
            rdata_q  <= '0;
            reg_wr_q <= '0;
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= '0;
            end
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ridx_q   <= ridx_d;
            rdata_q  <= rdata_d;
            reg_wr_q <= reg_wr_d;
            for (int n = 0; n < NREG; n++) begin
                regs_q[n] <= regs_d[n];
            end
        end
    end

    // Handshake outputs decode straight from state flops, never from bus inputs.
    assign s00_axi.awready = (wstate_q == W_ACCEPT);
    assign s00_axi.wready  = (wstate_q == W_ACCEPT);
    assign s00_axi.bvalid  = (wstate_q == W_RESP);
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = (rstate_q == R_ACCEPT);
    assign s00_axi.rvalid  = (rstate_q == R_DATA);
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;
    assign reg_wr_o        = reg_wr_q;

    always_comb begin
        reg_o = '0;
        for (int n = 0; n < NREG; n++) begin
            reg_o[n*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs_q[n];
        end
    end
endmodule

// File: tb/tb_tdc_axil_regs.sv
// Bench for tdc_axil_regs: directed scenarios plus randomized traffic against a byte-level model.
module tb_tdc_axil_regs;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] reg_o;
    logic [3:0]   reg_wr;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic [31:0]  model [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    tdc_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    tdc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus),
        .reg_o           (reg_o),
        .reg_wr_o        (reg_wr)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] apply_strobe(input logic [31:0] old_v, input logic [31:0] new_v,
                                                 input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int acc_lat, output int b_lat,
                             output logic [1:0] resp, output logic [3:0] pulse);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awprot = 3'($urandom);
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        acc_lat = 0;
        do begin tick(); acc_lat++; end while (!(bus.awready && bus.wready) && acc_lat < 20);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        b_lat = 0;
        while (!bus.bvalid && b_lat < 20) begin tick(); b_lat++; end
        resp = bus.bresp;
        pulse = reg_wr;
        tick();
    endtask

    task automatic bus_read(input logic [3:0] a, output int acc_lat, output int r_lat,
                            output logic [31:0] data, output logic [1:0] resp);
        bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1'b1; bus.rready = 1'b1;
        acc_lat = 0;
        do begin tick(); acc_lat++; end while (!bus.arready && acc_lat < 20);
        tick();
        bus.arvalid = 1'b0;
        r_lat = 0;
        while (!bus.rvalid && r_lat < 20) begin tick(); r_lat++; end
        data = bus.rdata;
        resp = bus.rresp;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_bus();
        repeat (3) tick();
        n_cmp++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin
            n_bad++; $display("FAIL reset_handshake: got %b expected 00000",
                {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid});
        end
        n_cmp++;
        if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        n_cmp++;
        if (reg_o !== 128'h0 || reg_wr !== 4'h0) begin
            n_bad++; $display("FAIL reset_regs: reg_o %h reg_wr %b expected all zero", reg_o, reg_wr);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        tick();
        n_cmp++;
        if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_idle: awready %b arready %b expected 0 0", bus.awready, bus.arready);
        end
    endtask

    task automatic test_sequential;
        int al, bl; logic [1:0] rs; logic [3:0] p; logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            bus_write(4'(i * 4), 32'(i + 1), 4'hF, al, bl, rs, p);
            model[i] = 32'(i + 1);
            n_cmp++;
            if (al !== 1 || bl !== 0 || rs !== 2'b00) begin
                n_bad++; $display("FAIL seq_write_timing[%0d]: acc %0d bvalid-wait %0d resp %b expected 1 0 00", i, al, bl, rs);
            end
            n_cmp++;
            if (p !== 4'(1 << i)) begin n_bad++; $display("FAIL seq_write_pulse[%0d]: got %b expected %b", i, p, 4'(1 << i)); end
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), al, bl, d, rs);
            n_cmp++;
            if (d !== model[i] || rs !== 2'b00 || al !== 1 || bl !== 0) begin
                n_bad++; $display("FAIL seq_read[%0d]: data %h resp %b acc %0d wait %0d expected %h 00 1 0", i, d, rs, al, bl, model[i]);
            end
        end
        n_cmp++;
        if (reg_o !== 128'h00000004_00000003_00000002_00000001) begin
            n_bad++; $display("FAIL seq_reg_o: got %h expected 00000004000000030000000200000001", reg_o);
        end
    endtask

    task automatic test_strobes;
        int al, bl; logic [1:0] rs; logic [3:0] p; logic [31:0] d;
        bus_write(4'h4, 32'hAABBCCDD, 4'hF, al, bl, rs, p);
        model[1] = apply_strobe(model[1], 32'hAABBCCDD, 4'hF);
        bus_write(4'h4, 32'h11223344, 4'b0101, al, bl, rs, p);
        model[1] = apply_strobe(model[1], 32'h11223344, 4'b0101);
        bus_read(4'h4, al, bl, d, rs);
        n_cmp++;
        if (d !== 32'hAA22CC44) begin n_bad++; $display("FAIL strobe_merge: got %h expected aa22cc44", d); end
        bus_write(4'h4, $urandom, 4'b0000, al, bl, rs, p);
        n_cmp++;
        if (p !== 4'b0010 || rs !== 2'b00) begin
            n_bad++; $display("FAIL strobe_zero_pulse: pulse %b resp %b expected 0010 00", p, rs);
        end
        bus_read(4'h4, al, bl, d, rs);
        n_cmp++;
        if (d !== model[1]) begin n_bad++; $display("FAIL strobe_zero_keep: got %h expected %h", d, model[1]); end
    endtask

    task automatic test_split_backpressure;
        logic [31:0] d1, d2;
        d1 = $urandom; d2 = $urandom;
        bus.awaddr = 4'h8; bus.wdata = d1; bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                n_bad++; $display("FAIL split_wait[%0d]: awready %b wready %b expected 0 0", k, bus.awready, bus.wready);
            end
        end
        bus.wvalid = 1'b1;
        tick();
        n_cmp++;
        if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            n_bad++; $display("FAIL split_accept: awready %b wready %b expected 1 1", bus.awready, bus.wready);
        end
        tick();
        model[2] = d1;
        // A second request waits on the bus for the whole response phase.
        bus.awaddr = 4'hC; bus.wdata = d2;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold[%0d]: bvalid %b awready %b wready %b expected 1 0 0", k, bus.bvalid, bus.awready, bus.wready);
            end
            n_cmp++;
            if (reg_wr !== ((k == 0) ? 4'b0100 : 4'b0000)) begin
                n_bad++; $display("FAIL bp_pulse[%0d]: got %b expected %b", k, reg_wr, (k == 0) ? 4'b0100 : 4'b0000);
            end
            if (k == 3) bus.bready = 1'b1;
            tick();
        end
        n_cmp++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b0) begin
            n_bad++; $display("FAIL bp_release: bvalid %b awready %b expected 0 0", bus.bvalid, bus.awready);
        end
        tick();
        n_cmp++;
        if (bus.awready !== 1'b1) begin n_bad++; $display("FAIL bp_second_accept: got %b expected 1", bus.awready); end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        model[3] = d2;
        tick();
        n_cmp++;
        if (reg_o !== {model[3], model[2], model[1], model[0]}) begin
            n_bad++; $display("FAIL split_reg_o: got %h expected %h", reg_o, {model[3], model[2], model[1], model[0]});
        end
    endtask

    task automatic test_concurrent;
        int al, bl; logic [1:0] rs; logic [3:0] p; logic [31:0] d;
        bus_write(4'h8, 32'h3, 4'hF, al, bl, rs, p);
        model[2] = 32'h3;
        bus.araddr = 4'h8; bus.arvalid = 1'b1; bus.rready = 1'b1;
        bus.awaddr = 4'h8; bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        tick();
        n_cmp++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
            n_bad++; $display("FAIL conc_accept: arready %b awready %b expected 1 1", bus.arready, bus.awready);
        end
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== model[2] || bus.bvalid !== 1'b1) begin
            n_bad++; $display("FAIL conc_old_value: rvalid %b rdata %h bvalid %b expected 1 %h 1", bus.rvalid, bus.rdata, bus.bvalid, model[2]);
        end
        model[2] = 32'h99;
        tick();
        bus_read(4'h8, al, bl, d, rs);
        n_cmp++;
        if (d !== 32'h99) begin n_bad++; $display("FAIL conc_new_value: got %h expected 00000099", d); end
    endtask

    task automatic test_alias;
        int al, bl; logic [1:0] rs; logic [3:0] p; logic [31:0] d, v;
        v = $urandom;
        bus_write(4'h7, v, 4'hF, al, bl, rs, p);
        model[1] = v;
        n_cmp++;
        if (p !== 4'b0010) begin n_bad++; $display("FAIL alias_pulse: got %b expected 0010", p); end
        bus_read(4'h5, al, bl, d, rs);
        n_cmp++;
        if (d !== v) begin n_bad++; $display("FAIL alias_read: got %h expected %h", d, v); end
    endtask

    task automatic test_random;
        int al, bl; logic [1:0] rs; logic [3:0] p, a, s; logic [31:0] d, v;
        int bad_before;
        bad_before = n_bad;
        for (int it = 0; it < 40; it++) begin
            a = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v = $urandom; s = 4'($urandom);
                bus_write(a, v, s, al, bl, rs, p);
                model[a / 4] = apply_strobe(model[a / 4], v, s);
                n_cmp++;
                if (p !== 4'(1 << (a / 4)) || rs !== 2'b00 || al !== 1 || bl !== 0) begin
                    n_bad++; $display("FAIL rand_write[%0d]: addr %h pulse %b resp %b acc %0d wait %0d", it, a, p, rs, al, bl);
                end
            end else begin
                bus_read(a, al, bl, d, rs);
                n_cmp++;
                if (d !== model[a / 4] || rs !== 2'b00) begin
                    n_bad++; $display("FAIL rand_read[%0d]: addr %h got %h expected %h", it, a, d, model[a / 4]);
                end
            end
        end
        n_cmp++;
        if (reg_o !== {model[3], model[2], model[1], model[0]}) begin
            n_bad++; $display("FAIL rand_reg_o: got %h expected %h", reg_o, {model[3], model[2], model[1], model[0]});
        end
        if (n_bad != bad_before) $display("random section saw %0d errors", n_bad - bad_before);
    endtask

    task automatic test_back_to_back;
        int al, bl, start; logic [1:0] rs; logic [3:0] p; logic [31:0] d, v;
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            bus_write(4'(i * 4), v, 4'hF, al, bl, rs, p);
            model[i] = v;
        end
        n_cmp++;
        if (cyc - start !== 12) begin n_bad++; $display("FAIL b2b_write_cycles: got %0d expected 12", cyc - start); end
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), al, bl, d, rs);
            n_cmp++;
            if (d !== model[i]) begin n_bad++; $display("FAIL b2b_read[%0d]: got %h expected %h", i, d, model[i]); end
        end
        n_cmp++;
        if (cyc - start !== 12) begin n_bad++; $display("FAIL b2b_read_cycles: got %0d expected 12", cyc - start); end
    endtask

    task automatic test_drop_valid;
        bus.araddr = 4'hC; bus.arvalid = 1'b1; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        n_cmp++;
        if (bus.arready !== 1'b1) begin n_bad++; $display("FAIL drop_accept: got %b expected 1", bus.arready); end
        tick();
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== model[3]) begin
            n_bad++; $display("FAIL drop_data: rvalid %b rdata %h expected 1 %h", bus.rvalid, bus.rdata, model[3]);
        end
        tick();
        n_cmp++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            n_bad++; $display("FAIL drop_idle: rvalid %b arready %b expected 0 0", bus.rvalid, bus.arready);
        end
    endtask

    task automatic test_reset_mid;
        int al, bl; logic [1:0] rs; logic [31:0] d;
        bus.araddr = 4'h4; bus.arvalid = 1'b1; bus.rready = 1'b0;
        bus.awaddr = 4'h0; bus.wdata = $urandom; bus.wstrb = 4'hF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.bready = 1'b0;
        tick();
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n_cmp++;
        if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1) begin
            n_bad++; $display("FAIL midrst_setup: rvalid %b bvalid %b expected 1 1", bus.rvalid, bus.bvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0 || reg_o !== 128'h0 || reg_wr !== 4'h0) begin
            n_bad++; $display("FAIL midrst_async: rvalid %b bvalid %b reg_o %h reg_wr %b expected all zero", bus.rvalid, bus.bvalid, reg_o, reg_wr);
        end
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        idle_bus();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i * 4), al, bl, d, rs);
            n_cmp++;
            if (d !== model[i]) begin n_bad++; $display("FAIL midrst_read[%0d]: got %h expected %h", i, d, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_strobes();
        test_split_backpressure();
        test_concurrent();
        test_alias();
        test_random();
        test_back_to_back();
        test_drop_valid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
